// File: rtl/strobe_checker.sv
// strobe_checker: receive-side monitor for a periodic single-cycle strobe.
// Measures strobe spacing, locks after LOCK_CNT correctly spaced intervals,
// and flags early or missing strobes once locked.
module strobe_checker #(
  parameter int PERIOD   = 3,   // expected spacing, 2..254
  parameter int LOCK_CNT = 4,   // good intervals to lock, 1..15
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             reset,      // async, active-low
  input  logic             strobe,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_count,
  output logic [7:0]       interval
);

  typedef enum logic [1:0] {IDLE, ACQ, LOCKED} state_t;

  localparam logic [8:0]       PER9    = 9'(PERIOD);
  localparam logic [7:0]       SLOT    = 8'(PERIOD - 1);
  localparam logic [3:0]       LOCK4   = 4'(LOCK_CNT);
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  state_t     state, state_nxt;
  logic [7:0] ivl;
  logic [3:0] good_cnt, good_nxt;
  logic       err_nxt;
  logic       int_upd;
  logic [8:0] meas;
  logic       slot_miss;

  // Spacing measured at this strobe; 9 bits so a saturated ivl does not wrap.
  assign meas      = {1'b0, ivl} + 9'd1;
  // Expected slot passed with no strobe.
  assign slot_miss = !strobe && (ivl == SLOT);
  assign locked    = (state == LOCKED);

  // Next-state, good-interval count and error decision.
  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    err_nxt   = 1'b0;
    int_upd   = 1'b0;
    case (state)
      IDLE: begin
        // First strobe only starts timing.
        if (strobe) begin
          state_nxt = ACQ;
          good_nxt  = 4'd0;
        end
      end
      ACQ: begin
        if (strobe) begin
          int_upd = 1'b1;
          if (meas == PER9) begin
            if (good_cnt + 4'd1 == LOCK4) begin
              state_nxt = LOCKED;
              good_nxt  = 4'd0;
            end else begin
              good_nxt = good_cnt + 4'd1;
            end
          end else begin
            good_nxt = 4'd0;         // early: restart the run, no error yet
          end
        end else if (slot_miss) begin
          state_nxt = IDLE;
          good_nxt  = 4'd0;
        end
      end
      LOCKED: begin
        if (strobe) begin
          int_upd = 1'b1;
          if (meas != PER9) begin    // early strobe
            err_nxt   = 1'b1;
            state_nxt = ACQ;
            good_nxt  = 4'd0;
          end
        end else if (slot_miss) begin // missing strobe
          err_nxt   = 1'b1;
          state_nxt = IDLE;
          good_nxt  = 4'd0;
        end
      end
      default: begin
        state_nxt = IDLE;
        good_nxt  = 4'd0;
      end
    endcase
  end

  // State and good-interval count registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      good_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      good_cnt <= good_nxt;
    end
  end

  // Interval counter: cleared on strobe, otherwise counts up to 255 and holds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)             ivl <= 8'd0;
    else if (strobe)        ivl <= 8'd0;
    else if (ivl != 8'hFF)  ivl <= ivl + 8'd1;
  end

  // Last measured spacing, clamped to 255 for the 8-bit output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       interval <= 8'd0;
    else if (int_upd) interval <= meas[8] ? 8'hFF : meas[7:0];
  end

  // Registered error pulse and saturating error counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      err <= err_nxt;
      if (err_nxt && err_count != ERR_MAX) err_count <= err_count + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_strobe_checker.sv
// tb_strobe_checker: directed and randomized checks of strobe_checker against
// a cycle-index based reference model.
module tb_strobe_checker;
  localparam int P  = 3;
  localparam int L  = 4;
  localparam int EW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          strobe = 1'b0;
  logic          locked, err;
  logic [EW-1:0] err_count;
  logic [7:0]    interval;

  strobe_checker #(.PERIOD(P), .LOCK_CNT(L), .ERR_W(EW)) dut (
    .clk(clk), .reset(reset), .strobe(strobe),
    .locked(locked), .err(err), .err_count(err_count), .interval(interval)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cn = 0;                 // index of the cycle currently being driven

  // Reference model: mode 0 idle, 1 acquiring, 2 locked; timing via absolute
  // cycle index of the last strobe.
  int m_mode, m_good, m_last, m_cnt, m_int;
  bit m_err;

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      failures++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cn);
    end
  endtask

  task automatic model_clear();
    m_mode = 0; m_good = 0; m_last = 0; m_cnt = 0; m_int = 0; m_err = 0;
  endtask

  task automatic model_step(input bit s);
    int gap;
    m_err = 0;
    if (m_mode == 0) begin
      if (s) begin m_mode = 1; m_good = 0; m_last = cn; end
    end else begin
      gap = cn - m_last;
      if (s) begin
        m_int  = (gap > 255) ? 255 : gap;
        m_last = cn;
        if (gap == P) begin
          if (m_mode == 1) begin
            m_good++;
            if (m_good == L) m_mode = 2;
          end
        end else begin
          if (m_mode == 2) m_err = 1;
          m_mode = 1; m_good = 0;
        end
      end else if (gap == P) begin
        if (m_mode == 2) m_err = 1;
        m_mode = 0;
      end
    end
    if (m_err && m_cnt < (1 << EW) - 1) m_cnt++;
  endtask

  task automatic compare();
    chk("locked",    locked,    (m_mode == 2) ? 1 : 0);
    chk("err",       err,       m_err ? 1 : 0);
    chk("err_count", err_count, m_cnt);
    chk("interval",  interval,  m_int);
  endtask

  // Drive one cycle, advance the model at the edge, compare at the negedge.
  task automatic tick(input bit s);
    strobe = s;
    @(posedge clk);
    if (reset) model_step(s);
    cn++;
    @(negedge clk);
    compare();
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic async_reset(input string nm, input bit zero_cn);
    reset = 1'b0;
    #1;
    chk({nm, "_locked"},   locked,    0);
    chk({nm, "_err"},      err,       0);
    chk({nm, "_errcount"}, err_count, 0);
    chk({nm, "_interval"}, interval,  0);
    model_clear();
    tick(1'b1);               // strobe during reset must be ignored
    reset = 1'b1;
    if (zero_cn) cn = 0;
  endtask

  initial begin
    int pulses, any_lock, any_err, sf, nxt, r, gap;
    bit s;
    model_clear();
    #2;
    async_reset("rst", 1'b1);

    // T1: clean lock, a missed strobe, then relock.
    while (cn < 13) begin
      tick(cn % 3 == 0);
      if (cn == 12) chk("t1_not_yet_locked", locked, 0);
    end
    chk("t1_locked_13", locked, 1);
    chk("t1_interval", interval, 3);
    chk("t1_no_err", err, 0);
    chk("t1_errcount0", err_count, 0);
    while (cn < 16) tick(cn % 3 == 0 && cn != 15);
    chk("t1_miss_err16", err, 1);
    chk("t1_miss_unlock16", locked, 0);
    chk("t1_miss_cnt1", err_count, 1);
    tick(1'b0);
    chk("t1_err_one_cycle", err, 0);
    while (cn < 31) begin
      tick(cn % 3 == 0 && cn >= 18);
      if (cn == 30) chk("t1_relock_not_yet", locked, 0);
    end
    chk("t1_relock_31", locked, 1);

    // T2: extra strobe while locked.
    async_reset("rst2", 1'b1);
    while (cn < 14) tick(cn % 3 == 0);
    tick(1'b1);
    chk("t2_early_err", err, 1);
    chk("t2_early_unlock", locked, 0);
    chk("t2_early_interval", interval, 2);
    chk("t2_early_cnt", err_count, 1);

    // T3: spacing 2 then spacing 4: never locks, never errors.
    async_reset("rst3", 1'b1);
    any_lock = 0; any_err = 0;
    while (cn < 20) begin
      tick(cn % 2 == 0);
      any_lock |= int'(locked); any_err |= int'(err);
    end
    chk("t3_interval2", interval, 2);
    while (cn < 60) begin
      tick(cn % 4 == 0);
      any_lock |= int'(locked); any_err |= int'(err);
    end
    chk("t3_never_locked", any_lock, 0);
    chk("t3_never_err", any_err, 0);

    // T4: repeated lock + missed strobe saturates the 4-bit counter.
    async_reset("rst4", 1'b1);
    pulses = 0;
    for (int b = 0; b < 17; b++) begin
      for (int k = 0; k < 18; k++) begin
        tick(k % 3 == 0 && k != 15);
        pulses += int'(err);
      end
    end
    chk("t4_pulses", pulses, 17);
    chk("t4_saturated", err_count, 15);

    // T5: async reset while locked, then relock from the first new strobe.
    async_reset("rst5", 1'b1);
    while (cn < 20) tick(cn % 3 == 0);
    chk("t5_locked_before", locked, 1);
    async_reset("arst", 1'b0);
    sf = -1;
    repeat (30) begin
      if (sf < 0 && cn % 3 == 0) sf = cn;
      tick(cn % 3 == 0);
      if (sf >= 0 && cn == sf + 12) chk("t5_relock_not_yet", locked, 0);
      if (sf >= 0 && cn == sf + 13) chk("t5_relock", locked, 1);
    end

    // T6: randomized spacing with occasional early, late and bursty strobes.
    async_reset("rst6", 1'b1);
    nxt = 0;
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) async_reset("arst6", 1'b0);
      s = (nxt == 0);
      if (s) begin
        r = int'($urandom_range(0, 99));
        if (r < 70)      gap = P;
        else if (r < 80) gap = int'($urandom_range(1, P - 1));
        else if (r < 90) gap = int'($urandom_range(P + 1, P + 4));
        else             gap = 1;
        nxt = gap - 1;
      end else begin
        nxt--;
      end
      tick(s);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
